dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_rr.sv | 31 +++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int NUM_PORTS  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef logic [0:0] port_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Owner selection for the data-memory arbiter.
// DMEM_ARB_FIXED_PRIO_EN: port 0 always wins conflicts; otherwise the port not last granted wins.
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_t                ptr,
  output logic [NUM_PORTS-1:0] sel
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    sel = '0;
    case (req)
      2'b01:   sel = 2'b01;
      2'b10:   sel = 2'b10;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      2'b11:   sel = 2'b01;
`else
      // ptr is the last granted port, so the other one goes next
      2'b11:   sel = (ptr == port_t'(1)) ? 2'b01 : 2'b10;
`endif
      default: sel = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE latches one command, BUSY issues it for one cycle.
// Optional DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            REQ,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] A0,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [DATA_WIDTH-1:0] WD0,
  input  logic [DATA_WIDTH-1:0] WD1,
  output logic [1:0]            GNT,
  output logic [1:0]            RVALID,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_A,
  output logic [DATA_WIDTH-1:0] MEM_WD,
  input  logic [DATA_WIDTH-1:0] MEM_RD
);

  state_e                state_q, state_d;
  port_t                 ptr_q, owner_q;
  logic                  lat_we_q;
  logic [ADDR_WIDTH-1:0] lat_a_q;
  logic [DATA_WIDTH-1:0] lat_wd_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [1:0]            rvalid_q;
  logic [1:0]            sel;
  logic                  latch_en;
  port_t                 sel_port;

  dmem_arb_rr u_rr (
    .req (REQ),
    .ptr (ptr_q),
    .sel (sel)
  );

  assign sel_port = port_t'(sel[1]);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    GNT      = '0;
    MEM_WE   = 1'b0;
    MEM_A    = '0;
    MEM_WD   = '0;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          state_d  = BUSY;
          latch_en = 1'b1;
        end
      end
      BUSY: begin
        state_d = IDLE;
        GNT     = port_onehot(owner_q);
        // a write overlapping reset must never reach memory
        MEM_WE  = lat_we_q & ~RST;
        MEM_A   = lat_a_q;
        MEM_WD  = lat_wd_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q    <= port_t'(1);
      owner_q  <= '0;
      lat_we_q <= 1'b0;
      lat_a_q  <= '0;
      lat_wd_q <= '0;
      rd_q     <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= '0;
      if (latch_en) begin
        owner_q  <= sel_port;
        ptr_q    <= sel_port;
        lat_we_q <= sel[1] ? WE1 : WE0;
        lat_a_q  <= sel[1] ? A1  : A0;
        lat_wd_q <= sel[1] ? WD1 : WD0;
      end
      if (state_q == BUSY && !lat_we_q) begin
        rd_q     <= MEM_RD;
        rvalid_q <= port_onehot(owner_q);
      end
    end
  end

  assign RD     = rd_q;
  assign RVALID = rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  REQ = '0;
  logic        WE0 = 1'b0, WE1 = 1'b0;
  logic [31:0] A0 = '0, A1 = '0, WD0 = '0, WD1 = '0;
  logic [1:0]  GNT, RVALID;
  logic [31:0] RD, MEM_A, MEM_WD, MEM_RD;
  logic        MEM_WE;

  int chks = 0;
  int errs = 0;

  logic [31:0] ram [16];
  logic        ram_clr = 1'b0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else if (MEM_WE) begin
      ram[MEM_A[5:2]] <= MEM_WD;
    end
  end
  assign MEM_RD = ram[MEM_A[5:2]];

  dmem_arbiter dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE0(WE0), .WE1(WE1),
    .A0(A0), .A1(A1), .WD0(WD0), .WD1(WD1),
    .GNT(GNT), .RVALID(RVALID), .RD(RD),
    .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
  );

  task automatic test_reset;
    REQ = '0; RST = 1'b1; ram_clr = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chks++; if (GNT !== 2'b00) begin errs++; $display("FAIL reset_gnt got %b want 00", GNT); end
    chks++; if (RVALID !== 2'b00) begin errs++; $display("FAIL reset_rvalid got %b want 00", RVALID); end
    chks++; if (RD !== 32'h0) begin errs++; $display("FAIL reset_rd got %h want 0", RD); end
    chks++; if (MEM_WE !== 1'b0 || MEM_A !== 32'h0 || MEM_WD !== 32'h0) begin
      errs++; $display("FAIL reset_mem got we=%b a=%h wd=%h want 0/0/0", MEM_WE, MEM_A, MEM_WD);
    end
    RST = 1'b0; ram_clr = 1'b0;
  endtask

  task automatic test_write_read;
    REQ = 2'b01; WE0 = 1'b1; A0 = 32'h10; WD0 = 32'hDEADBEEF;
    @(posedge CLK); #1;
    chks++; if (GNT !== 2'b01) begin errs++; $display("FAIL wr_gnt got %b want 01", GNT); end
    chks++; if (MEM_WE !== 1'b1 || MEM_A !== 32'h10 || MEM_WD !== 32'hDEADBEEF) begin
      errs++; $display("FAIL wr_cmd got we=%b a=%h wd=%h want 1/10/deadbeef", MEM_WE, MEM_A, MEM_WD);
    end
    chks++; if (RVALID !== 2'b00) begin errs++; $display("FAIL wr_rvalid_busy got %b want 00", RVALID); end
    REQ = 2'b00;
    @(posedge CLK); #1;
    chks++; if (RVALID !== 2'b00) begin errs++; $display("FAIL wr_rvalid_after got %b want 00", RVALID); end
    REQ = 2'b10; WE1 = 1'b0; A1 = 32'h10; WD1 = 32'h0;
    @(posedge CLK); #1;
    chks++; if (GNT !== 2'b10 || MEM_WE !== 1'b0 || MEM_A !== 32'h10) begin
      errs++; $display("FAIL rd_busy got gnt=%b we=%b a=%h want 10/0/10", GNT, MEM_WE, MEM_A);
    end
    REQ = 2'b00;
    @(posedge CLK); #1;
    chks++; if (RD !== 32'hDEADBEEF || RVALID !== 2'b10) begin
      errs++; $display("FAIL rd_data got rd=%h rvalid=%b want deadbeef/10", RD, RVALID);
    end
    @(posedge CLK); #1;
    chks++; if (RD !== 32'hDEADBEEF || RVALID !== 2'b00 || GNT !== 2'b00) begin
      errs++; $display("FAIL rd_hold got rd=%h rvalid=%b gnt=%b want deadbeef/00/00", RD, RVALID, GNT);
    end
  endtask

  task automatic test_conflict;
    logic [1:0] exp;
    test_reset();
    REQ = 2'b11; WE0 = 1'b0; WE1 = 1'b0; A0 = 32'h0; A1 = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp = 2'b01;
`else
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chks++; if (GNT !== exp) begin errs++; $display("FAIL conflict_%0d got %b want %b", i, GNT, exp); end
      @(posedge CLK); #1;
      chks++; if (GNT !== 2'b00) begin errs++; $display("FAIL conflict_idle_%0d got %b want 00", i, GNT); end
    end
    REQ = 2'b00;
    @(posedge CLK); #1;
  endtask

  task automatic test_rst_busy;
    REQ = 2'b01; WE0 = 1'b1; A0 = 32'h10; WD0 = 32'hCAFEF00D;
    @(posedge CLK); #1; REQ = 2'b00;
    @(posedge CLK); #1;
    REQ = 2'b01; WE0 = 1'b0;
    @(posedge CLK); #1; REQ = 2'b00;
    @(posedge CLK); #1;
    chks++; if (RD !== 32'hCAFEF00D) begin errs++; $display("FAIL rstb_pre_rd got %h want cafef00d", RD); end
    REQ = 2'b01; WE0 = 1'b1; A0 = 32'h20; WD0 = 32'h12345678;
    @(posedge CLK); #1;
    chks++; if (GNT !== 2'b01 || MEM_WE !== 1'b1) begin
      errs++; $display("FAIL rstb_busy got gnt=%b we=%b want 01/1", GNT, MEM_WE);
    end
    RST = 1'b1; REQ = 2'b00;
    #1;
    chks++; if (MEM_WE !== 1'b0) begin errs++; $display("FAIL rstb_gate got %b want 0", MEM_WE); end
    @(posedge CLK); #1;
    RST = 1'b0;
    chks++; if (GNT !== 2'b00 || RVALID !== 2'b00 || RD !== 32'h0) begin
      errs++; $display("FAIL rstb_after got gnt=%b rvalid=%b rd=%h want 00/00/0", GNT, RVALID, RD);
    end
    chks++; if (ram[8] !== 32'h0) begin errs++; $display("FAIL rstb_mem got %h want 0", ram[8]); end
    @(posedge CLK); #1;
    chks++; if (GNT !== 2'b00 || RVALID !== 2'b00) begin
      errs++; $display("FAIL rstb_idle got gnt=%b rvalid=%b want 00/00", GNT, RVALID);
    end
  endtask

  task automatic test_idle;
    REQ = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chks++; if (GNT !== 2'b00 || MEM_WE !== 1'b0) begin
        errs++; $display("FAIL idle_%0d got gnt=%b we=%b want 00/0", i, GNT, MEM_WE);
      end
    end
  endtask

  // Transaction model: pending commands per port, last-granted port, expected memory image.
  task automatic test_random;
    logic        pend [2];
    logic        pwe  [2];
    logic [31:0] pa   [2];
    logic [31:0] pwd  [2];
    logic [31:0] mdl  [16];
    logic [31:0] exp_rd;
    logic [1:0]  exp_g;
    int          last, w;
    test_reset();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    pend[0] = 0; pend[1] = 0;
    last = 1; exp_rd = '0;
    for (int it = 0; it < 400; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          pwe[p]  = 1'($urandom_range(0, 1));
          pa[p]   = 32'($urandom_range(0, 15) * 4);
          pwd[p]  = $urandom;
        end
      end
      REQ = {pend[1], pend[0]};
      if (pend[0]) begin WE0 = pwe[0]; A0 = pa[0]; WD0 = pwd[0]; end
      else begin WE0 = 1'($urandom); A0 = $urandom; WD0 = $urandom; end
      if (pend[1]) begin WE1 = pwe[1]; A1 = pa[1]; WD1 = pwd[1]; end
      else begin WE1 = 1'($urandom); A1 = $urandom; WD1 = $urandom; end
      @(posedge CLK); #1;
      if (!pend[0] && !pend[1]) begin
        chks++; if (GNT !== 2'b00 || MEM_WE !== 1'b0 || RVALID !== 2'b00) begin
          errs++; $display("FAIL rnd_idle_%0d got gnt=%b we=%b rv=%b want 00/0/00", it, GNT, MEM_WE, RVALID);
        end
        continue;
      end
`ifdef DMEM_ARB_FIXED_PRIO_EN
      w = (pend[0] && pend[1]) ? 0 : (pend[1] ? 1 : 0);
`else
      w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
`endif
      exp_g = (w == 1) ? 2'b10 : 2'b01;
      chks++; if (GNT !== exp_g || MEM_WE !== pwe[w] || MEM_A !== pa[w] || MEM_WD !== pwd[w]) begin
        errs++; $display("FAIL rnd_busy_%0d got gnt=%b we=%b a=%h wd=%h want %b/%b/%h/%h",
                         it, GNT, MEM_WE, MEM_A, MEM_WD, exp_g, pwe[w], pa[w], pwd[w]);
      end
      if (pwe[w]) mdl[pa[w][5:2]] = pwd[w];
      else        exp_rd = mdl[pa[w][5:2]];
      last = w; pend[w] = 1'b0;
      REQ = {pend[1], pend[0]};
      @(posedge CLK); #1;
      chks++; if (RVALID !== (pwe[w] ? 2'b00 : exp_g) || RD !== exp_rd) begin
        errs++; $display("FAIL rnd_done_%0d got rv=%b rd=%h want %b/%h",
                         it, RVALID, RD, pwe[w] ? 2'b00 : exp_g, exp_rd);
      end
    end
    REQ = 2'b00;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_rst_busy();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end

endmodule
